uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Two-requester UART transmit scheduler that shares a single serial line. It arbitrates round-robin between two byte sources and sequences an 11-bit frame: start bit, 8 data bits LSB-first, even parity, stop bit. Bit timing is paced by the 16x oversampling tick from the baud controller. It sits between the baud controller's `sample_ENABLE` output and the `TxD` pin, and is the only driver of `TxD`.

## Interface
- `TICKS_PER_BIT`, 16: number of `sample_ENABLE` pulses per serial bit; must be a power of two, at least 2.
- `reset` input 1: asynchronous, active-high.
- `clock` input 1: system clock, rising edge.
- `sample_ENABLE` input 1: single-cycle 16x baud tick from the baud controller.
- `req` input 2: `req[i]` high means requester i has a byte on `data_i`; held until `ack[i]`.
- `data_0` input 8: byte from requester 0; sampled on its grant edge only.
- `data_1` input 8: byte from requester 1; sampled on its grant edge only.
- `ack` output 2: one-cycle pulse on the grant edge; at most one bit set.
- `tx_busy` output 1: high from the grant edge until the frame completes.
- `tx_done` output 1: one-cycle pulse at the end of the stop bit.
- `TxD` output 1: serial line; idle high.

## Operation
- Reset values:
  - `TxD`=1, `tx_busy`=0, `tx_done`=0, `ack`=2'b00.
  - State IDLE; tick counter 0; bit index 0.
  - `last_grant`=1, so requester 0 wins the first tie.
- States: IDLE → START → DATA (8 bits) → PARITY → STOP → IDLE.
- IDLE, `req`==0: hold `TxD`=1, `tx_busy`=0.
- IDLE, exactly one `req` bit set: grant that requester.
- IDLE, both `req` bits set: grant the requester not equal to `last_grant`.
- Grant edge:
  - Latch the granted byte into the shift register.
  - Compute parity = XOR of the 8 latched bits (even parity).
  - Pulse `ack[i]`, set `tx_busy`=1, update `last_grant`=i, enter START.
- START drives `TxD`=0.
- DATA drives `TxD` = shift register bit 0, then shifts right; bit index counts 0..7.
- PARITY drives `TxD` = the latched parity bit. STOP drives `TxD`=1.
- Tick counter:
  - Increments only on `sample_ENABLE` while not IDLE.
  - A bit ends on the `sample_ENABLE` that takes the counter from `TICKS_PER_BIT`-1 to 0 (wrap).
  - At that point the FSM advances to the next bit.
- STOP bit end: pulse `tx_done`, clear `tx_busy`, return to IDLE. Arbitration resumes on the next cycle, not in the same cycle.
- Requests arriving while busy wait; `req` is not latched.
- If a requester drops `req` before being granted, nothing is sent for it.
- `data_i` changes after `ack` do not affect the frame in flight.
- `reset` mid-frame: outputs take their reset values immediately. The frame is truncated and `TxD` returns high. No `tx_done` is pulsed.

## Timing
- All outputs are registered; `TxD` is glitch-free.
- Grant latency: `ack` and `tx_busy` rise on the first rising edge at which IDLE and `req`!=0.
- `TxD` falls on that same edge.
- Start-bit duration: from the grant edge to the 16th subsequent `sample_ENABLE`, inclusive.
- Every later bit lasts exactly `TICKS_PER_BIT` ticks.
- `sample_ENABLE` coinciding with the grant edge is not counted.
- `tx_done` is asserted in the cycle after the final tick's edge. `tx_busy` is 0 in that same cycle.
- Earliest next `ack` is one cycle after `tx_done`.
- Back-to-back frames therefore have at least one idle-high clock between the stop bit and the next start bit.

## Test plan
- **Reset:** assert `reset` asynchronously with no clock → `TxD`=1, `tx_busy`=0, `ack`=0, `tx_done`=0.
- **Single frame:**
  - Stimulus: `sample_ENABLE` every 4 clocks; `req`=01, `data_0`=8'hA5.
  - `ack`=01 for 1 cycle.
  - `TxD` sequence per 16 ticks: 0, 1,0,1,0,0,1,0,1, 0 (parity), 1 (stop).
  - `tx_done` about 704 clocks after grant; `tx_busy` low at the same time.
- **Parity:** `data_1`=8'h07 via `req`=10 → parity bit 1. `data_1`=8'h00 → parity bit 0 and frame 0,00000000,0,1.
- **Round-robin:**
  - `req`=11 held continuously after reset.
  - Grants alternate 0, 1, 0, 1 across four frames.
  - Each grant occurs exactly one cycle after the previous `tx_done`.
- **Mid-frame data change:**
  - Change `data_0` from 8'h3C to 8'hFF during DATA bit 3.
  - Transmitted byte is still 8'h3C; parity is 0.
- **Reset mid-frame:**
  - Assert `reset` during DATA bit 5 → `TxD`=1 immediately; no `tx_done`.
  - After release with `req`=11, requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one UART transmit line between two byte sources.
// Round-robin arbitration in IDLE, then an 11-bit frame (start, 8 data bits
// LSB-first, even parity, stop) paced by the 16x oversampling tick.
module uart_tx_scheduler #(
    parameter int unsigned TICKS_PER_BIT = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sample_ENABLE,
    input  logic [1:0] req,
    input  logic [7:0] data_0,
    input  logic [7:0] data_1,
    output logic [1:0] ack,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       TxD
);

    // Tick counter wide enough for 0..TICKS_PER_BIT-1; a power of two wraps naturally.
    localparam int unsigned CNT_W = (TICKS_PER_BIT > 2) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TICKS_PER_BIT - 1);
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;
    localparam logic [IDX_W-1:0] LAST_DATA_BIT = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   tick_cnt;
    logic [IDX_W-1:0]   bit_idx;
    logic [DATA_W-1:0]  shreg;
    logic               parity;
    logic               last_grant;

    logic               grant_sel;
    logic [DATA_W-1:0]  grant_data;
    logic               bit_end;

    // Arbitration: a lone request wins; on a tie the requester not served last wins.
    always_comb begin
        grant_sel = 1'b0;
        case (req)
            2'b10:   grant_sel = 1'b1;
            2'b11:   grant_sel = ~last_grant;
            default: grant_sel = 1'b0;
        endcase
    end

    assign grant_data = grant_sel ? data_1 : data_0;

    // A serial bit ends on the tick that wraps the counter; ticks in IDLE never count.
    assign bit_end = (state != IDLE) && sample_ENABLE && (tick_cnt == LAST_TICK);

    // Oversampling tick counter, cleared while idle so every frame starts aligned to its grant.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (state == IDLE) begin
            tick_cnt <= '0;
        end else if (sample_ENABLE) begin
            tick_cnt <= bit_end ? '0 : tick_cnt + CNT_W'(1);
        end
    end

    // Frame sequencer with registered line, handshake and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bit_idx    <= '0;
            shreg      <= '0;
            parity     <= 1'b0;
            last_grant <= 1'b1;
            ack        <= 2'b00;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            TxD        <= 1'b1;
        end else begin
            ack     <= 2'b00;
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    TxD     <= 1'b1;
                    tx_busy <= 1'b0;
                    bit_idx <= '0;
                    if (req != 2'b00) begin
                        shreg      <= grant_data;
                        parity     <= ^grant_data;
                        ack        <= grant_sel ? 2'b10 : 2'b01;
                        last_grant <= grant_sel;
                        tx_busy    <= 1'b1;
                        TxD        <= 1'b0;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        TxD     <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == LAST_DATA_BIT) begin
                            TxD   <= parity;
                            state <= PARITY;
                        end else begin
                            TxD     <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        TxD   <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        tx_done <= 1'b1;
                        tx_busy <= 1'b0;
                        TxD     <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    TxD     <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed and randomized frames checked against a
// frame-level model (expected bit list per grant, round-robin history).
module tb_uart_tx_scheduler;

    localparam int unsigned TPB         = 16;
    localparam int unsigned NBITS       = 11;
    localparam int unsigned FRAME_TICKS = TPB * NBITS;

    logic       clock;
    logic       reset;
    logic       sample_ENABLE;
    logic [1:0] req;
    logic [7:0] data_0;
    logic [7:0] data_1;
    logic [1:0] ack;
    logic       tx_busy;
    logic       tx_done;
    logic       TxD;

    int   tests    = 0;
    int   failures = 0;
    bit   run_clk  = 0;
    bit   tick_on  = 0;
    int   period   = 4;
    int   cyc      = 0;
    logic se_edge  = 1'b0;
    int   m_last   = 1;

    uart_tx_scheduler #(.TICKS_PER_BIT(TPB)) dut (
        .clock         (clock),
        .reset         (reset),
        .sample_ENABLE (sample_ENABLE),
        .req           (req),
        .data_0        (data_0),
        .data_1        (data_1),
        .ack           (ack),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .TxD           (TxD)
    );

    initial clock = 1'b0;
    always #5 if (run_clk) clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; remembers the tick the DUT saw at this edge, then schedules the next tick.
    task automatic step();
        se_edge = sample_ENABLE;
        @(posedge clock);
        #1;
        cyc++;
        sample_ENABLE = tick_on && ((cyc % period) == 0);
    endtask

    task automatic idle_quiet(input int n, input string tag);
        int acks = 0;
        int lows = 0;
        int busy = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (ack !== 2'b00) acks++;
            if (TxD !== 1'b1) lows++;
            if (tx_busy !== 1'b0) busy++;
        end
        check({tag, "_ack"}, acks, 0);
        check({tag, "_txd"}, lows, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    // Waits for a grant, predicts it from req history, then follows the whole frame.
    task automatic expect_frame(input bit drop, input int rst_tick, input int chg_tick,
                                input logic [7:0] chg_val, input bit blip,
                                output int g, output int waited);
        logic [1:0]  r;
        logic [7:0]  d0s, d1s, d;
        logic [10:0] fr;
        logic [1:0]  exp_ack;
        bit          seen;
        int          ticks, steps, cyc_grant, lat, dones;
        g = -1; waited = 0; seen = 0; r = 2'b00; d0s = '0; d1s = '0;
        while (!seen && waited < 2000) begin
            r = req; d0s = data_0; d1s = data_1;
            step();
            waited++;
            seen = (ack !== 2'b00);
        end
        check("grant_seen", seen, 1);
        if (!seen) return;
        if (r == 2'b01)      g = 0;
        else if (r == 2'b10) g = 1;
        else if (r == 2'b11) g = 1 - m_last;
        exp_ack = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        check("ack", ack, exp_ack);
        check("busy_at_grant", tx_busy, 1);
        check("start_edge", TxD, 0);
        check("done_at_grant", tx_done, 0);
        if (g < 0) return;
        m_last = g;
        d  = (g == 1) ? d1s : d0s;
        fr = {1'b1, ^d, d, 1'b0};
        if (drop) req[g] = 1'b0;
        cyc_grant = cyc; ticks = 0; steps = 0;
        while (ticks < FRAME_TICKS && steps < FRAME_TICKS * period + 64) begin
            step();
            steps++;
            if (steps == 1) check("ack_pulse", ack, 0);
            if (se_edge) begin
                ticks++;
                if (ticks < FRAME_TICKS &&
                    ((ticks % TPB) == 0 || (ticks % TPB) == 8 || (ticks % TPB) == TPB - 1)) begin
                    check($sformatf("txd_t%0d", ticks), TxD, fr[ticks / TPB]);
                    check($sformatf("busy_t%0d", ticks), tx_busy, 1);
                    check($sformatf("done_t%0d", ticks), tx_done, 0);
                end
                if (blip && ticks == 40)  req[1] = 1'b1;
                if (blip && ticks == 120) req[1] = 1'b0;
                if (chg_tick > 0 && ticks == chg_tick) data_0 = chg_val;
                if (rst_tick > 0 && ticks == rst_tick) begin
                    #2 reset = 1'b1;
                    #1;
                    check("rst_txd", TxD, 1);
                    check("rst_busy", tx_busy, 0);
                    check("rst_ack", ack, 0);
                    check("rst_done", tx_done, 0);
                    req = 2'b00;
                    dones = 0;
                    repeat (3) begin
                        step();
                        if (tx_done !== 1'b0) dones++;
                    end
                    reset = 1'b0;
                    m_last = 1;
                    for (int i = 0; i < 20; i++) begin
                        step();
                        if (tx_done !== 1'b0) dones++;
                    end
                    check("rst_no_done", dones, 0);
                    check("rst_idle_txd", TxD, 1);
                    return;
                end
            end
        end
        check("frame_complete", ticks, FRAME_TICKS);
        if (ticks < FRAME_TICKS) return;
        check("done_pulse", tx_done, 1);
        check("busy_clear", tx_busy, 0);
        check("stop_idle", TxD, 1);
        lat = cyc - cyc_grant;
        check("done_latency", (lat > (FRAME_TICKS - 1) * period) && (lat <= FRAME_TICKS * period), 1);
    endtask

    initial begin
        int g, w;
        reset = 1'b0; req = 2'b00; data_0 = '0; data_1 = '0; sample_ENABLE = 1'b0;

        // Asynchronous reset with the clock stopped.
        #3 reset = 1'b1;
        #2;
        check("reset_txd", TxD, 1);
        check("reset_busy", tx_busy, 0);
        check("reset_ack", ack, 0);
        check("reset_done", tx_done, 0);
        run_clk = 1;
        repeat (2) step();
        reset = 1'b0; m_last = 1;
        tick_on = 1; period = 4;
        idle_quiet(10, "idle");

        // Single frame, 0xA5 from requester 0.
        data_0 = 8'hA5; req = 2'b01;
        expect_frame(1, 0, 0, 8'h00, 0, g, w);
        check("single_grant", g, 0);

        // Parity of 0x07 and 0x00 from requester 1.
        data_1 = 8'h07; req = 2'b10;
        expect_frame(1, 0, 0, 8'h00, 0, g, w);
        check("par07_grant", g, 1);
        data_1 = 8'h00; req = 2'b10;
        expect_frame(1, 0, 0, 8'h00, 0, g, w);
        check("par00_grant", g, 1);

        // Requester 1 raises then drops req while busy: nothing sent for it.
        data_0 = 8'($urandom); data_1 = 8'h5A; req = 2'b01;
        expect_frame(1, 0, 0, 8'h00, 1, g, w);
        idle_quiet(40, "dropped");

        // data_0 changes during data bit 3; frame keeps the latched 0x3C.
        data_0 = 8'h3C; req = 2'b01;
        expect_frame(1, 0, 72, 8'hFF, 0, g, w);

        // Round-robin with both requests held after a reset.
        reset = 1'b1;
        step();
        reset = 1'b0; m_last = 1;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            data_0 = 8'($urandom); data_1 = 8'($urandom);
            expect_frame(0, 0, 0, 8'h00, 0, g, w);
            check($sformatf("rr_grant%0d", i), g, i % 2);
            if (i > 0) check($sformatf("rr_gap%0d", i), w, 1);
        end
        req = 2'b00;
        idle_quiet(5, "rr_end");

        // Reset during data bit 5, then requester 0 wins the first tie.
        data_0 = 8'($urandom); data_1 = 8'($urandom); req = 2'b11;
        expect_frame(0, 104, 0, 8'h00, 0, g, w);
        req = 2'b11;
        expect_frame(1, 0, 0, 8'h00, 0, g, w);
        check("post_rst_grant", g, 0);
        req = 2'b00;
        idle_quiet(3, "post_rst");

        // Randomized frames across tick rates, including a tick every clock.
        for (int i = 0; i < 10; i++) begin
            period = int'($urandom_range(1, 4));
            data_0 = 8'($urandom); data_1 = 8'($urandom);
            req = 2'($urandom_range(1, 3));
            expect_frame(1, 0, ($urandom_range(0, 1) == 1) ? 100 : 0, 8'($urandom), 0, g, w);
        end
        req = 2'b00;
        idle_quiet(5, "final");

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
